// File: rtl/game_mem_arbiter_pkg.sv
// Shared types and constants for the game memory arbiter.
package game_mem_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ENTRIES_DEF    = 16;
    localparam int NUM_REQ        = 3;

    typedef logic [1:0]         req_idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

    // Requester indices; round-robin order follows increasing index.
    localparam req_idx_t REQ_KB = 2'd0;
    localparam req_idx_t REQ_GL = 2'd1;
    localparam req_idx_t REQ_DP = 2'd2;

    typedef enum logic {
        ARB,
        CLEAR
    } state_e;

    // Index of the set bit in a one-hot requester vector.
    function automatic req_idx_t onehot_to_idx(input req_vec_t v);
        req_idx_t idx;
        idx = REQ_KB;
        if (v[REQ_GL]) idx = REQ_GL;
        if (v[REQ_DP]) idx = REQ_DP;
        return idx;
    endfunction

endpackage

// File: rtl/game_mem_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: the search starts just after the
// last granted requester and wraps kb -> gl -> dp -> kb.
module game_mem_arbiter_rr_pick
    import game_mem_arbiter_pkg::*;
(
    input  req_vec_t elig,
    input  req_idx_t last,
    output req_vec_t win,
    output logic     valid
);

    req_idx_t first_idx;
    req_idx_t second_idx;
    req_idx_t third_idx;

    // Rotate the search order so the last winner is checked last.
    always_comb begin
        case (last)
            REQ_KB: begin
                first_idx  = REQ_GL;
                second_idx = REQ_DP;
                third_idx  = REQ_KB;
            end
            REQ_GL: begin
                first_idx  = REQ_DP;
                second_idx = REQ_KB;
                third_idx  = REQ_GL;
            end
            default: begin
                first_idx  = REQ_KB;
                second_idx = REQ_GL;
                third_idx  = REQ_DP;
            end
        endcase
    end

    // Grant the first eligible requester in rotated order.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        win   = '0;
        valid = 1'b1;
        if (elig[first_idx])       win[first_idx]  = 1'b1;
        else if (elig[second_idx]) win[second_idx] = 1'b1;
        else if (elig[third_idx])  win[third_idx]  = 1'b1;
        else                       valid = 1'b0;
    end

endmodule

// File: rtl/game_mem_arbiter.sv
// Shares the single-port game memory between keyboard, game logic and the
// display scanner; also runs the memory clear sweep.
module game_mem_arbiter
    import game_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ENTRIES    = ENTRIES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_game,
    input  logic                  clear_req,
    output logic                  clear_done,
    input  logic                  kb_req,
    input  logic [ADDR_WIDTH-1:0] kb_addr,
    input  logic [DATA_WIDTH-1:0] kb_wdata,
    output logic                  kb_gnt,
    output logic                  kb_nack,
    input  logic                  gl_req,
    input  logic                  gl_we,
    input  logic                  gl_lock,
    input  logic [ADDR_WIDTH-1:0] gl_addr,
    input  logic [DATA_WIDTH-1:0] gl_wdata,
    output logic                  gl_gnt,
    output logic                  gl_rvalid,
    input  logic                  dp_req,
    input  logic [ADDR_WIDTH-1:0] dp_addr,
    output logic                  dp_gnt,
    output logic                  dp_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // One extra bit so the sweep counter can reach ENTRIES itself.
    localparam int CNT_W = ADDR_WIDTH + 1;

    state_e                state_q,     state_d;
    req_idx_t              ptr_q,       ptr_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    req_vec_t              gnt_q,       gnt_d;
    logic                  nack_q,      nack_d;
    logic                  done_q,      done_d;
    logic                  gl_rvalid_q, gl_rvalid_d;
    logic                  dp_rvalid_q, dp_rvalid_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    req_vec_t elig;
    req_vec_t pick_win;
    logic     pick_valid;
    req_idx_t win_idx;

    // A lock hides everyone but game logic; keyboard is shut out once the game starts.
    assign elig[REQ_KB] = kb_req & ~start_game & ~gl_lock;
    assign elig[REQ_GL] = gl_req;
    assign elig[REQ_DP] = dp_req & ~gl_lock;

    game_mem_arbiter_rr_pick u_pick (
        .elig  (elig),
        .last  (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign win_idx = onehot_to_idx(pick_win);

    // Next-state logic for the ARB/CLEAR FSM, command registers and read-valid stage.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        nack_d      = 1'b0;
        done_d      = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // Read data returns one cycle after the read command; the grant tags its owner.
        gl_rvalid_d = gnt_q[REQ_GL] & ~mem_we_q;
        dp_rvalid_d = gnt_q[REQ_DP] & ~mem_we_q;

        case (state_q)
            ARB: begin
                if (clear_req) begin
                    // Clear outranks every request, lock included; address 0 goes out now.
                    state_d     = CLEAR;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    cnt_d       = CNT_W'(1);
                end else begin
                    nack_d = kb_req & start_game;
                    if (pick_valid) begin
                        gnt_d = pick_win;
                        ptr_d = win_idx;
                        case (win_idx)
                            REQ_KB: begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = kb_addr;
                                mem_wdata_d = kb_wdata;
                            end
                            REQ_GL: begin
                                mem_we_d    = gl_we;
                                mem_addr_d  = gl_addr;
                                mem_wdata_d = gl_wdata;
                            end
                            default: begin
                                mem_addr_d  = dp_addr;
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (cnt_q == CNT_W'(ENTRIES)) begin
                    state_d = ARB;
                    done_d  = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = '0;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // State and output registers; reset drops any pending rvalid and partial clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= REQ_DP;
            cnt_q       <= '0;
            gnt_q       <= '0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            gl_rvalid_q <= 1'b0;
            dp_rvalid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            nack_q      <= nack_d;
            done_q      <= done_d;
            gl_rvalid_q <= gl_rvalid_d;
            dp_rvalid_q <= dp_rvalid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign kb_gnt     = gnt_q[REQ_KB];
    assign gl_gnt     = gnt_q[REQ_GL];
    assign dp_gnt     = gnt_q[REQ_DP];
    assign kb_nack    = nack_q;
    assign gl_rvalid  = gl_rvalid_q;
    assign dp_rvalid  = dp_rvalid_q;
    assign clear_done = done_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rdata      = mem_rdata;

endmodule
